// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array front end: loader FSM states,
// default lane/address widths and the write-pipeline record.
package systolic_pkg;

  localparam int DEF_ARRAY_N    = 8;
  localparam int DEF_ARRAY_M    = 8;
  localparam int DEF_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_W,
    ST_FINISH
  } ld_state_e;

  // One read in flight: which phase it belongs to and its destination lane.
  typedef struct packed {
    logic        vld_a;
    logic        vld_w;
    logic [31:0] lane;
  } wr_pipe_t;

  function automatic logic [31:0] word_off(input logic [31:0] idx);
    return idx << 2;
  endfunction

endpackage

// File: rtl/loader_addr_gen.sv
// (k, lane) counter pair shared by the A and W phases. The linear word index
// k*lanes+lane is kept as a running count, so no multiplier is needed.
module loader_addr_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_adv,
  input  logic [31:0] i_lanes,
  input  logic [31:0] i_kmax,
  output logic [31:0] o_lane,
  output logic [31:0] o_idx,
  output logic        o_last
);

  logic [31:0] r_lane;
  logic [31:0] r_k;
  logic [31:0] r_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lane <= '0;
      r_k    <= '0;
      r_idx  <= '0;
    end else if (i_clr) begin
      r_lane <= '0;
      r_k    <= '0;
      r_idx  <= '0;
    end else if (i_adv) begin
      r_idx <= r_idx + 32'd1;
      if (r_lane == i_lanes - 32'd1) begin
        r_lane <= '0;
        r_k    <= r_k + 32'd1;
      end else begin
        r_lane <= r_lane + 32'd1;
      end
    end
  end

  assign o_lane = r_lane;
  assign o_idx  = r_idx;
  assign o_last = (r_lane == i_lanes - 32'd1) && (r_k == i_kmax - 32'd1);

endmodule

// File: rtl/operand_loader.sv
// Streams A (MxK) then W (KxN) words from PS BRAM into per-lane operand
// buffers. Define OPERAND_LOADER_STALL_EN to add the 'hold' back-pressure input.
module operand_loader
  import systolic_pkg::*;
#(
  parameter int ARRAY_N    = DEF_ARRAY_N,
  parameter int ARRAY_M    = DEF_ARRAY_M,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           M,
  input  logic [31:0]           K,
  input  logic [31:0]           N,
  input  logic [31:0]           a_src_base,
  input  logic [31:0]           w_src_base,
`ifdef OPERAND_LOADER_STALL_EN
  input  logic                  hold,
`endif
  output logic [31:0]           bram_addr,
  output logic                  bram_en,
  input  logic [31:0]           bram_rd_data,
  output logic [31:0]           a_w_data,
  output logic [ADDR_WIDTH-1:0] a_w_addr,
  output logic [ARRAY_N-1:0]    a_w_en,
  output logic [31:0]           w_w_data,
  output logic [ADDR_WIDTH-1:0] w_w_addr,
  output logic [ARRAY_M-1:0]    w_w_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  ld_state_e             r_state;
  logic [31:0]           r_m, r_k, r_n, r_abase, r_wbase;
  logic                  r_done, r_err;
  wr_pipe_t              r_wr;
  logic [ADDR_WIDTH-1:0] r_wr_addr;

  logic        w_hold, w_load_a, w_load_w, w_rd, w_gen_clr, w_last, w_bad;
  logic        w_w_nz;
  logic [31:0] w_lanes, w_lane, w_idx;

`ifdef OPERAND_LOADER_STALL_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif

  assign w_load_a  = (r_state == ST_LOAD_A);
  assign w_load_w  = (r_state == ST_LOAD_W);
  assign w_rd      = (w_load_a || w_load_w) && !w_hold;
  assign w_lanes   = w_load_w ? r_n : r_m;
  assign w_w_nz    = (r_k != '0) && (r_n != '0);
  // Counters sit at zero in IDLE, so each phase starts from (0,0).
  assign w_gen_clr = (r_state == ST_IDLE) || (w_load_a && w_rd && w_last);
  assign w_bad     = (M > 32'(ARRAY_N)) || (N > 32'(ARRAY_M)) ||
                     ({1'b0, K} > (33'd1 << ADDR_WIDTH));

  loader_addr_gen u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_gen_clr),
    .i_adv   (w_rd),
    .i_lanes (w_lanes),
    .i_kmax  (r_k),
    .o_lane  (w_lane),
    .o_idx   (w_idx),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_m     <= '0;
      r_k     <= '0;
      r_n     <= '0;
      r_abase <= '0;
      r_wbase <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_m     <= M;
          r_k     <= K;
          r_n     <= N;
          r_abase <= a_src_base;
          r_wbase <= w_src_base;
          r_err   <= w_bad;
          if (w_bad)                        r_done  <= 1'b1;
          else if (M != '0 && K != '0)      r_state <= ST_LOAD_A;
          else if (K != '0 && N != '0)      r_state <= ST_LOAD_W;
          else                              r_state <= ST_FINISH;
        end
        ST_LOAD_A: if (w_rd && w_last) r_state <= w_w_nz ? ST_LOAD_W : ST_FINISH;
        ST_LOAD_W: if (w_rd && w_last) r_state <= ST_FINISH;
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Destination of the read issued this cycle; its data returns next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr      <= '0;
      r_wr_addr <= '0;
    end else begin
      r_wr.vld_a <= w_rd && w_load_a;
      r_wr.vld_w <= w_rd && w_load_w;
      r_wr.lane  <= w_lane;
      r_wr_addr  <= ADDR_WIDTH'(word_off(w_idx));
    end
  end

  assign bram_en   = w_rd;
  assign bram_addr = w_rd ? ((w_load_w ? r_wbase : r_abase) + word_off(w_idx)) : '0;

  assign a_w_en    = r_wr.vld_a ? (ARRAY_N'(1) << r_wr.lane) : '0;
  assign a_w_addr  = r_wr.vld_a ? r_wr_addr : '0;
  assign a_w_data  = r_wr.vld_a ? bram_rd_data : '0;
  assign w_w_en    = r_wr.vld_w ? (ARRAY_M'(1) << r_wr.lane) : '0;
  assign w_w_addr  = r_wr.vld_w ? r_wr_addr : '0;
  assign w_w_data  = r_wr.vld_w ? bram_rd_data : '0;

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: hand-computed latencies and counts, with
// a small in-order read/write sequence model. Hold vector needs OPERAND_LOADER_STALL_EN.
module tb_operand_loader;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] M, K, N, a_src_base, w_src_base;
  logic [31:0] bram_addr, bram_rd_data;
  logic        bram_en;
  logic [31:0] a_w_data, w_w_data;
  logic [7:0]  a_w_addr, w_w_addr;
  logic [7:0]  a_w_en, w_w_en;
  logic        busy, done, err;
`ifdef OPERAND_LOADER_STALL_EN
  logic        hold = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  operand_loader dut (
    .clk(clk), .reset(reset), .start(start), .M(M), .K(K), .N(N),
    .a_src_base(a_src_base), .w_src_base(w_src_base),
`ifdef OPERAND_LOADER_STALL_EN
    .hold(hold),
`endif
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_rd_data(bram_rd_data),
    .a_w_data(a_w_data), .a_w_addr(a_w_addr), .a_w_en(a_w_en),
    .w_w_data(w_w_data), .w_w_addr(w_w_addr), .w_w_en(w_w_en),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // BRAM model: garbage when not read, so ungated write data is visible.
  always @(posedge clk) bram_rd_data <= bram_en ? rdf(bram_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input int m, input int k, input int n,
                     input logic [31:0] ab, input logic [31:0] wb,
                     input int exp_done, input int exp_busy, input logic exp_err,
                     input int xs_cyc, input int hs, input int hl);
    int c = 0, done_c = -1, done_n = 0, busy_n = 0, na = 0, nw = 0;
    int bad_rd = 0, bad_seq = 0, rd = 0, pr = -1, ta, tw, li, kk;
    logic err_at_done = 1'b0, held, xrd, aw, ww;
    logic [7:0]  ea, ew, eaa, ewa;
    logic [31:0] ead, ewd;
    ta = exp_err ? 0 : m * k;
    tw = exp_err ? 0 : k * n;
    @(negedge clk);
    M = m; K = k; N = n; a_src_base = ab; w_src_base = wb; start = 1'b1;
    while (c < 700 && !(done_c >= 0 && c >= done_c + 4)) begin
      @(posedge clk);
      #1;
      c++;
      start = (c == xs_cyc);
      held  = (c >= hs) && (c < hs + hl);
`ifdef OPERAND_LOADER_STALL_EN
      hold = held;
`endif
      @(negedge clk);
      xrd = !held && (rd < ta + tw);
      if (bram_en !== xrd) bad_rd++;
      else if (xrd && bram_addr !== ((rd < ta) ? ab + rd * 4 : wb + (rd - ta) * 4)) bad_rd++;
      aw = (pr >= 0) && (pr < ta);
      ww = (pr >= ta);
      ea = '0; eaa = '0; ead = '0; ew = '0; ewa = '0; ewd = '0;
      if (aw) begin
        li = pr % m; kk = pr / m;
        ea = 8'd1 << li; eaa = 8'((kk * m + li) * 4); ead = rdf(ab + pr * 4);
      end
      if (ww) begin
        li = (pr - ta) % n; kk = (pr - ta) / n;
        ew = 8'd1 << li; ewa = 8'((kk * n + li) * 4); ewd = rdf(wb + (pr - ta) * 4);
      end
      if (a_w_en !== ea || a_w_addr !== eaa || a_w_data !== ead) bad_seq++;
      if (w_w_en !== ew || w_w_addr !== ewa || w_w_data !== ewd) bad_seq++;
      if (a_w_en != '0) na++;
      if (w_w_en != '0) nw++;
      if (busy) busy_n++;
      if (done) begin done_n++; done_c = c; err_at_done = err; end
      pr = xrd ? rd : -1;
      if (xrd) rd++;
    end
    start = 1'b0;
    chk({tag, "_done_cyc"}, done_c, exp_done);
    chk({tag, "_done_cnt"}, done_n, 1);
    chk({tag, "_err"}, {31'd0, err_at_done}, {31'd0, exp_err});
    chk({tag, "_a_writes"}, na, ta);
    chk({tag, "_w_writes"}, nw, tw);
    chk({tag, "_rd_seq"}, bad_rd, 0);
    chk({tag, "_wr_seq"}, bad_seq, 0);
    if (exp_busy >= 0) chk({tag, "_busy_cyc"}, busy_n, exp_busy);
  endtask

  initial begin
    int q;
    reset = 1'b0; start = 1'b0;
    M = '0; K = '0; N = '0; a_src_base = '0; w_src_base = '0;
    #3;
    chk("rst_ctl", {28'd0, bram_en, busy, done, err}, 32'd0);
    chk("rst_bram_addr", bram_addr, 32'd0);
    chk("rst_wen", {16'd0, a_w_en, w_w_en}, 32'd0);
    chk("rst_wdata", a_w_data | w_w_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    //   tag          m  k    n  abase        wbase        done busy err xs hs hl
    run("mkn2",       2, 2,   2, 32'h0,       32'h100,     10,  9,   0,  0, 0, 0);
    run("full8",      8, 8,   8, 32'h1000,    32'h2000,    130, 129, 0,  0, 0, 0);
    run("m9",         9, 2,   2, 32'h0,       32'h100,     1,   0,   1,  0, 0, 0);
    run("k0",         3, 0,   3, 32'h0,       32'h100,     2,   -1,  0,  0, 0, 0);
    run("busy_start", 2, 2,   2, 32'h40,      32'h80,      10,  9,   0,  4, 0, 0);
    run("n0",         3, 2,   0, 32'h200,     32'h300,     8,   7,   0,  0, 0, 0);
    run("n9",         1, 1,   9, 32'h0,       32'h0,       1,   0,   1,  0, 0, 0);
    run("k256",       1, 256, 1, 32'h8000,    32'h9000,    514, 513, 0,  0, 0, 0);
    run("k257",       1, 257, 1, 32'h0,       32'h0,       1,   0,   1,  0, 0, 0);

    // Reset asserted in cycle 5 of an M=K=N=4 load.
    @(negedge clk);
    M = 4; K = 4; N = 4; a_src_base = 32'h0; w_src_base = 32'h100; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (c == 4) chk("midrst_pre_busy", {31'd0, busy}, 32'd1);
    end
    reset = 1'b0;
    #1;
    chk("midrst_ctl", {28'd0, bram_en, busy, done, err}, 32'd0);
    chk("midrst_bram_addr", bram_addr, 32'd0);
    chk("midrst_wen", {16'd0, a_w_en, w_w_en}, 32'd0);
    chk("midrst_wdata", a_w_data | w_w_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    q = 0;
    repeat (20) begin
      @(negedge clk);
      if (bram_en || busy || done || a_w_en != '0 || w_w_en != '0) q++;
    end
    chk("midrst_quiet", q, 0);
    run("resume",     2, 2,   2, 32'h0,       32'h100,     10,  9,   0,  0, 0, 0);

`ifdef OPERAND_LOADER_STALL_EN
    run("hold3",      2, 2,   2, 32'h0,       32'h100,     13,  12,  0,  0, 2, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
